// File: rtl/serial_frame_pkg.sv
// serial_frame_pkg
//   Shared definitions for the serial frame transmitter.
//   - state_t   : 3-bit FSM state encoding (IDLE, PRE, DELIM, DATA, PAR, GAP)
//   - cnt_width : width of the shared down-counter, sized so the largest
//                 segment length (preamble, payload or gap) fits as a load value.
package serial_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_DELIM = 3'd2,
    ST_DATA  = 3'd3,
    ST_PAR   = 3'd4,
    ST_GAP   = 3'd5
  } state_t;

  function automatic int cnt_width(input int pre_len, input int data_w, input int gap_len);
    int m;
    m = pre_len;
    if (data_w > m) m = data_w;
    if (gap_len > m) m = gap_len;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/serial_frame_tx.sv
// serial_frame_tx
//   Serializes a parallel word into a framed bit stream for the downstream
//   consecutive-ones detector:
//     preamble (PREAMBLE_LEN ones) | delimiter (one zero) | data, MSB first |
//     [parity] | gap (GAP_LEN zeros)
//
//   Build option:
//     PARITY_EN - when defined, one even-parity bit (XOR of the latched word)
//                 is inserted between the data and the gap.
//
//   Ports:
//     clk       in   single clock, rising edge
//     rst_n     in   asynchronous active-low reset; aborts any frame in flight
//     tx_data   in   word to send, sampled on the handshake
//     tx_valid  in   upstream has a word
//     tx_ready  out  block can accept a word (IDLE only, decoded from state)
//     tx_bit    out  serial output bit, registered
//     tx_active out  high for every cycle of a frame on tx_bit
//     tx_done   out  one-cycle pulse on the final gap bit
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | tx_bit=0, waiting for a word; tx_ready=1
//   PRE   | sending PREAMBLE_LEN ones
//   DELIM | sending the single zero delimiter
//   DATA  | sending DATA_W payload bits, MSB first
//   PAR   | sending the even-parity bit (PARITY_EN builds only)
//   GAP   | sending GAP_LEN zeros; tx_done on the last one
module serial_frame_tx
  import serial_frame_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int PREAMBLE_LEN = 2,
  parameter int GAP_LEN      = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_bit,
  output logic              tx_active,
  output logic              tx_done
);

  localparam int CW = cnt_width(PREAMBLE_LEN, DATA_W, GAP_LEN);

  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_TWO = CW'(2);
  localparam logic [CW-1:0] PRE_LD  = CW'(PREAMBLE_LEN);
  localparam logic [CW-1:0] DATA_LD = CW'(DATA_W);
  localparam logic [CW-1:0] GAP_LD  = CW'(GAP_LEN);
  localparam logic          GAP_ONE = (GAP_LEN == 1);

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [CW-1:0]     cnt;
`ifdef PARITY_EN
  logic              par;
`endif

  assign tx_ready = (state == ST_IDLE);

  // Every state is entered with the counter loaded to its segment length and
  // left when the counter reads 1. Outputs are registered alongside the state
  // so tx_bit always shows the bit belonging to the current state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      cnt       <= '0;
      tx_bit    <= 1'b0;
      tx_active <= 1'b0;
      tx_done   <= 1'b0;
`ifdef PARITY_EN
      par       <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          tx_bit    <= 1'b0;
          tx_active <= 1'b0;
          tx_done   <= 1'b0;
          if (tx_valid) begin
            state     <= ST_PRE;
            shreg     <= tx_data;
            cnt       <= PRE_LD;
            tx_bit    <= 1'b1;
            tx_active <= 1'b1;
`ifdef PARITY_EN
            par       <= ^tx_data;
`endif
          end
        end

        ST_PRE: begin
          if (cnt == CNT_ONE) begin
            state  <= ST_DELIM;
            cnt    <= CNT_ONE;
            tx_bit <= 1'b0;
          end else begin
            cnt    <= cnt - CNT_ONE;
            tx_bit <= 1'b1;
          end
        end

        // The delimiter is always one cycle long, so it always exits here.
        ST_DELIM: begin
          state  <= ST_DATA;
          cnt    <= DATA_LD;
          tx_bit <= shreg[DATA_W-1];
          shreg  <= shreg << 1;
        end

        ST_DATA: begin
          if (cnt == CNT_ONE) begin
`ifdef PARITY_EN
            state   <= ST_PAR;
            cnt     <= CNT_ONE;
            tx_bit  <= par;
`else
            state   <= ST_GAP;
            cnt     <= GAP_LD;
            tx_bit  <= 1'b0;
            tx_done <= GAP_ONE;
`endif
          end else begin
            cnt    <= cnt - CNT_ONE;
            tx_bit <= shreg[DATA_W-1];
            shreg  <= shreg << 1;
          end
        end

`ifdef PARITY_EN
        ST_PAR: begin
          state   <= ST_GAP;
          cnt     <= GAP_LD;
          tx_bit  <= 1'b0;
          tx_done <= GAP_ONE;
        end
`endif

        // tx_done must line up with the last gap bit, so it is raised on the
        // edge that brings the counter down to 1.
        ST_GAP: begin
          if (cnt == CNT_ONE) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            tx_bit    <= 1'b0;
            tx_active <= 1'b0;
            tx_done   <= 1'b0;
          end else begin
            cnt     <= cnt - CNT_ONE;
            tx_bit  <= 1'b0;
            tx_done <= (cnt == CNT_TWO);
          end
        end

        default: begin
          state     <= ST_IDLE;
          cnt       <= '0;
          tx_bit    <= 1'b0;
          tx_active <= 1'b0;
          tx_done   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
module tb_serial_frame_tx;

  logic       clk;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, tx_bit, tx_active, tx_done;

  logic [0:0] tx2_data;
  logic       tx2_valid;
  logic       tx2_ready, tx2_bit, tx2_active, tx2_done;

  int n_cmp = 0;
  int n_err = 0;

  serial_frame_tx #(.DATA_W(8), .PREAMBLE_LEN(2), .GAP_LEN(1)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_bit(tx_bit), .tx_active(tx_active), .tx_done(tx_done)
  );

  serial_frame_tx #(.DATA_W(1), .PREAMBLE_LEN(3), .GAP_LEN(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx2_data), .tx_valid(tx2_valid),
    .tx_ready(tx2_ready), .tx_bit(tx2_bit), .tx_active(tx2_active), .tx_done(tx2_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  typedef struct {
    logic [7:0]  data;
    logic [11:0] bits;   // frame without parity, first bit in [11]
    logic        par;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string tag, input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s %s: got %0h expected %0h", tag, name, act, exp);
    end
  endtask

  function automatic void mk(input logic [11:0] base, input logic par,
                             output logic [15:0] bits, output int n);
`ifdef PARITY_EN
    bits = {3'b000, base[11:1], par, 1'b0};
    n    = 13;
`else
    bits = {4'b0000, base};
    n    = 12;
`endif
  endfunction

  task automatic idle_check(input string tag);
    chk(tag, "idle ready", tx_ready, 1'b1);
    chk(tag, "idle bit", tx_bit, 1'b0);
    chk(tag, "idle active", tx_active, 1'b0);
    chk(tag, "idle done", tx_done, 1'b0);
  endtask

  // Entered at the negedge of the first frame cycle; leaves at the negedge of
  // the last one. Optionally raises tx_valid with a new word mid-frame.
  task automatic check_frame(input logic [15:0] bits, input int n, input int inj_at,
                             input logic [7:0] inj_data, input string tag);
    for (int i = 0; i < n; i++) begin
      chk(tag, $sformatf("bit%0d", i), tx_bit, bits[n-1-i]);
      chk(tag, $sformatf("active%0d", i), tx_active, 1'b1);
      chk(tag, $sformatf("done%0d", i), tx_done, (i == n - 1));
      chk(tag, $sformatf("ready%0d", i), tx_ready, 1'b0);
      if (i == inj_at) begin
        tx_valid = 1'b1;
        tx_data  = inj_data;
      end
      if (i < n - 1) @(negedge clk);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic [11:0] base, input logic par,
                      input string tag);
    logic [15:0] bits;
    int n;
    mk(base, par, bits, n);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = ~d;
    check_frame(bits, n, -1, 8'h00, tag);
    @(negedge clk);
    idle_check(tag);
  endtask

  initial begin
    logic [15:0] bits;
    logic [15:0] bits2;
    int n;
    int n2;

    vecs[0] = '{8'hA5, 12'b11_0_10100101_0, 1'b0};
    vecs[1] = '{8'h3C, 12'b11_0_00111100_0, 1'b0};
    vecs[2] = '{8'hFF, 12'b11_0_11111111_0, 1'b0};
    vecs[3] = '{8'h00, 12'b11_0_00000000_0, 1'b0};
    vecs[4] = '{8'h01, 12'b11_0_00000001_0, 1'b1};
    vecs[5] = '{8'h80, 12'b11_0_10000000_0, 1'b1};

    rst_n     = 1'b0;
    tx_data   = 8'h00;
    tx_valid  = 1'b0;
    tx2_data  = 1'b0;
    tx2_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    idle_check("reset");
    chk("reset", "dut2 ready", tx2_ready, 1'b1);
    chk("reset", "dut2 bit", tx2_bit, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    idle_check("post-reset");

    for (int v = 0; v < 6; v++)
      send(vecs[v].data, vecs[v].bits, vecs[v].par, $sformatf("vec%0h", vecs[v].data));

    // Backpressure: 0x3C offered during the A5 frame must wait, then go out whole.
    mk(vecs[0].bits, vecs[0].par, bits, n);
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check_frame(bits, n, 2, 8'h3C, "bp-a5");
    @(negedge clk);
    idle_check("bp-gapidle");
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = 8'h55;
    mk(vecs[1].bits, vecs[1].par, bits, n);
    check_frame(bits, n, -1, 8'h00, "bp-3c");
    @(negedge clk);
    idle_check("bp-end");

    // Back-to-back: valid held high, word changes to 0x00 right after handshake.
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    @(negedge clk);
    mk(vecs[2].bits, vecs[2].par, bits, n);
    check_frame(bits, n, 0, 8'h00, "b2b-ff");
    @(negedge clk);
    idle_check("b2b-idle");
    @(negedge clk);
    tx_valid = 1'b0;
    mk(vecs[3].bits, vecs[3].par, bits, n);
    check_frame(bits, n, -1, 8'h00, "b2b-00");
    @(negedge clk);
    idle_check("b2b-end");

    // Reset during the 4th data bit (frame cycle 6) of an 0xFF frame.
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    for (int i = 0; i < 6; i++) @(negedge clk);
    chk("midrst", "bit before", tx_bit, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst", "bit", tx_bit, 1'b0);
    chk("midrst", "active", tx_active, 1'b0);
    chk("midrst", "ready", tx_ready, 1'b1);
    chk("midrst", "done", tx_done, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst", "done held", tx_done, 1'b0);
      chk("midrst", "bit held", tx_bit, 1'b0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    idle_check("midrst-release");
    send(vecs[0].data, vecs[0].bits, vecs[0].par, "after-rst");

    // Short word, long preamble and gap.
`ifdef PARITY_EN
    bits2 = 16'b111_0_1_1_0000;
    n2    = 10;
`else
    bits2 = 16'b111_0_1_0000;
    n2    = 9;
`endif
    tx2_data  = 1'b1;
    tx2_valid = 1'b1;
    @(negedge clk);
    tx2_valid = 1'b0;
    tx2_data  = 1'b0;
    for (int i = 0; i < n2; i++) begin
      chk("sweep", $sformatf("bit%0d", i), tx2_bit, bits2[n2-1-i]);
      chk("sweep", $sformatf("active%0d", i), tx2_active, 1'b1);
      chk("sweep", $sformatf("done%0d", i), tx2_done, (i == n2 - 1));
      chk("sweep", $sformatf("ready%0d", i), tx2_ready, 1'b0);
      if (i < n2 - 1) @(negedge clk);
    end
    @(negedge clk);
    chk("sweep", "idle ready", tx2_ready, 1'b1);
    chk("sweep", "idle active", tx2_active, 1'b0);
    chk("sweep", "idle bit", tx2_bit, 1'b0);
    chk("sweep", "idle done", tx2_done, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
